// File: rtl/ram_sp_pipe.sv
// ram_sp_pipe: single-port byte-writable RAM with a configurable-latency read pipeline and an optional clear sweep after reset.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   enable              access request, accepted only while ready is high
//   write_enable        per-byte write strobes; all-zero makes the access a read
//   data_ingress        write data
//   address             word address
//   data_egress         read data, held between valid pulses
//   egress_valid        one-cycle pulse qualifying data_egress
//   ready               high once the clear sweep has finished
module ram_sp_pipe #(
  parameter int DATA_WIDTH_P     = 32,
  parameter int ADDR_WIDTH_P     = 10,
  parameter int READ_LATENCY_P   = 1,
  parameter int WRITE_MODE_P     = 0,
  parameter int CLEAR_ON_RESET_P = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [DATA_WIDTH_P/8-1:0] write_enable,
  input  logic [DATA_WIDTH_P-1:0]   data_ingress,
  input  logic [ADDR_WIDTH_P-1:0]   address,
  output logic [DATA_WIDTH_P-1:0]   data_egress,
  output logic                      egress_valid,
  output logic                      ready
);
  localparam int NR_OF_BYTES_C = DATA_WIDTH_P / 8;
  localparam int DEPTH_C       = 2 ** ADDR_WIDTH_P;
  typedef enum logic {CLEAR_E, READY_E} state_e;
  state_e                    state_q;
  logic [ADDR_WIDTH_P-1:0]   cnt_q;
  logic [DATA_WIDTH_P-1:0]   mem_q [DEPTH_C];
  logic [DATA_WIDTH_P-1:0]   old_d;
  logic [DATA_WIDTH_P-1:0]   merged_d;
  logic                      acc;
  logic                      pv_d [READ_LATENCY_P+1];
  logic [DATA_WIDTH_P-1:0]   pd_d [READ_LATENCY_P+1];
  logic                      vld_q [READ_LATENCY_P];
  logic [DATA_WIDTH_P-1:0]   dat_q [READ_LATENCY_P];
  // The counter wraps to zero on the last word, but the state leaves CLEAR_E on that same edge so no re-clear occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET_P != 0) ? CLEAR_E : READY_E;
      cnt_q   <= '0;
    end else if (state_q == CLEAR_E) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH_P{1'b1}}) state_q <= READY_E;
    end
  end
  assign ready = (state_q == READY_E);
  // Gating with rst keeps a request in the reset cycle from writing or raising a valid.
  assign acc   = enable & ready & ~rst;
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR_E) begin
      mem_q[cnt_q] <= '0;
    end else if (acc) begin
      for (int i = 0; i < NR_OF_BYTES_C; i++)
        if (write_enable[i]) mem_q[address][8*i +: 8] <= data_ingress[8*i +: 8];
    end
  end
  always_comb begin
    old_d    = mem_q[address];
    merged_d = old_d;
    for (int i = 0; i < NR_OF_BYTES_C; i++)
      if (write_enable[i]) merged_d[8*i +: 8] = data_ingress[8*i +: 8];
  end
  // Entry 0 is the freshly accepted access; entry k+1 is the output of stage k.
  always_comb begin
    pv_d[0] = acc & ~(WRITE_MODE_P == 2 && |write_enable);
    pd_d[0] = (WRITE_MODE_P == 1) ? merged_d : old_d;
    for (int k = 0; k < READ_LATENCY_P; k++) begin
      pv_d[k+1] = vld_q[k];
      pd_d[k+1] = dat_q[k];
    end
  end
  // Data only moves with its valid bit, so the last stage naturally holds the last delivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY_P; k++) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < READ_LATENCY_P; k++) begin
        vld_q[k] <= pv_d[k];
        if (pv_d[k]) dat_q[k] <= pd_d[k];
      end
    end
  end
  assign egress_valid = vld_q[READ_LATENCY_P-1];
  assign data_egress  = dat_q[READ_LATENCY_P-1];
endmodule

// File: doc/ram_sp_pipe.md
RAM_SP_PIPE -- requirements
Module: ram_sp_pipe

Interface
REQ-001 Parameter DATA_WIDTH_P, default 32; word width in bits, multiple of 8, minimum 8.
REQ-002 Parameter ADDR_WIDTH_P, default 10; address width; depth is 2**ADDR_WIDTH_P words.
REQ-003 Parameter READ_LATENCY_P, default 1; cycles from accepted access to data_egress, legal range 1..3.
REQ-004 Parameter WRITE_MODE_P, default 0; read data on write access: 0 read-first, 1 write-first, 2 no-change.
REQ-005 Parameter CLEAR_ON_RESET_P, default 1; 1 clears the whole array to zero after reset, 0 skips clearing.
REQ-006 Derived NR_OF_BYTES_C = DATA_WIDTH_P/8.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 enable  input  1  access request, sampled each cycle.
REQ-010 write_enable  input  NR_OF_BYTES_C  per-byte write strobes; bit i covers data bits [8i+7:8i]; all-zero means read.
REQ-011 data_ingress  input  DATA_WIDTH_P  write data.
REQ-012 address  input  ADDR_WIDTH_P  word address.
REQ-013 data_egress  output  DATA_WIDTH_P  read data.
REQ-014 egress_valid  output  1  one-cycle pulse qualifying data_egress.
REQ-015 ready  output  1  high when accesses are accepted.

Function
REQ-016 Access accepted in cycle T iff enable=1 and ready=1; otherwise inputs ignored, no write, no egress_valid.
REQ-017 Accepted access with write_enable bit i set updates only byte i of mem[address] at end of T; other bytes keep value.
REQ-018 Accepted access produces egress_valid=1 and data_egress in cycle T+READ_LATENCY_P, except REQ-021.
REQ-019 Read-first (mode 0): data_egress returns the word as it was before the write in T.
REQ-020 Write-first (mode 1): data_egress returns the merged word (written bytes new, unwritten bytes old).
REQ-021 No-change (mode 2): access with any strobe set produces no egress_valid and data_egress holds its value.
REQ-022 Read pipeline fully pipelined: one accepted access per cycle, back-to-back, results in issue order, no bubbles.
REQ-023 data_egress holds last valid value whenever egress_valid=0.
REQ-024 FSM states CLEAR_E and READY_E; ready=1 only in READY_E.
REQ-025 CLEAR_E: counter starts at 0, writes all-zero word to mem[counter] each cycle, increments by 1.
REQ-026 CLEAR_E -> READY_E in the cycle counter equals 2**ADDR_WIDTH_P-1 (write of last word completes that cycle); clear takes exactly 2**ADDR_WIDTH_P cycles.
REQ-027 CLEAR_ON_RESET_P=0: FSM enters READY_E directly; ready=1 first cycle after rst deasserts; memory contents undefined until written.
REQ-028 Counter width ADDR_WIDTH_P+1 or terminal compare so no wrap-around re-clear occurs.
REQ-029 Accesses in flight when ready falls are not possible (ready only falls by reset); in-flight valids discarded by reset.

Reset
REQ-030 While rst=1: FSM to CLEAR_E (or READY_E if CLEAR_ON_RESET_P=0), counter 0, ready=0, egress_valid=0 and all pipeline valid bits 0, data_egress 0.
REQ-031 Reset asserted mid-clear restarts clear from address 0 after deassertion.
REQ-032 Memory array is not reset directly; only the clear sweep modifies it.

Verification (DATA 32, ADDR 4, LAT 2 unless stated)
REQ-033 Release rst, CLEAR 1 -> ready=0 for 16 cycles, ready=1 on 17th; read all 16 addresses -> 0x00000000 each, egress_valid 2 cycles after each accept.
REQ-034 Mode 0: write 0xAABBCCDD to addr 3 (strobe 0xF), then write 0x11223344 strobe 0x5 -> egress 0xAABBCCDD; subsequent read -> 0xAA22CC44.
REQ-035 Mode 1 same sequence -> second write returns 0xAA22CC44 at T+2; mode 2 -> no egress_valid on either write, data_egress unchanged.
REQ-036 16 back-to-back reads, LAT 1,2,3 -> 16 consecutive egress_valid pulses, data in address order, starting exactly LAT cycles after first accept.
REQ-037 enable=1 with strobe 0xF during clear at address 5, value 0xDEADBEEF -> no egress_valid; after ready, addr 5 reads 0.
REQ-038 Assert rst at clear counter 8 for 1 cycle -> clear restarts at 0, ready after further 16 cycles; pending read valids cleared.
